// File: rtl/ili9488_pkg.sv
// Shared types and constants for the ILI9488 display controllers (init, command, pixel paths).
package ili9488_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WINDOW = 2'd1,
    FILL   = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [15:0] COLOR_RED   = 16'hF800;
  localparam logic [15:0] COLOR_GREEN = 16'h07E0;
  localparam logic [15:0] COLOR_BLUE  = 16'h001F;
  localparam logic [15:0] COLOR_BLACK = 16'h0000;

  localparam int DEFAULT_H_RES = 320;
  localparam int DEFAULT_V_RES = 480;

  function automatic logic [15:0] palette(input logic [1:0] idx);
    case (idx)
      2'd0:    return COLOR_RED;
      2'd1:    return COLOR_GREEN;
      2'd2:    return COLOR_BLUE;
      default: return COLOR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/ili9488_frame_counter.sv
// Raster x/y position counter; advances one pixel per i_advance and wraps at the frame end.
module ili9488_frame_counter
  import ili9488_pkg::*;
#(
  parameter int   H_RES = DEFAULT_H_RES,
  parameter int   V_RES = DEFAULT_V_RES,
  localparam int  X_W   = (H_RES > 1) ? $clog2(H_RES) : 1,
  localparam int  Y_W   = (V_RES > 1) ? $clog2(V_RES) : 1
) (
  input  logic           clk,
  input  logic           reset_done,
  input  logic           i_advance,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_y,
  output logic           o_last_pixel
);

  localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic           w_line_end;
  logic           w_frame_end;

  assign w_line_end  = (r_x == X_LAST);
  assign w_frame_end = w_line_end && (r_y == Y_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset_done) begin
    if (reset_done) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_advance) begin
      if (w_line_end) begin
        r_x <= '0;
        r_y <= w_frame_end ? '0 : r_y + Y_W'(1);
      end else begin
        r_x <= r_x + X_W'(1);
      end
    end
  end

  assign o_x          = r_x;
  assign o_y          = r_y;
  assign o_last_pixel = w_frame_end;

endmodule

// File: rtl/ili9488_fill_sequencer.sv
// Frame sequencer for the colour-fill demo: window command, one solid frame, hold, next colour.
module ili9488_fill_sequencer
  import ili9488_pkg::*;
#(
  parameter int H_RES       = DEFAULT_H_RES,
  parameter int V_RES       = DEFAULT_V_RES,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        reset_done,
  input  logic        init_done,
  input  logic        enable,
  output logic        win_req,
  input  logic        win_ack,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [15:0] pix_data,
  output logic [1:0]  color_idx,
  output logic        frame_done,
  output logic        busy
);

  localparam int X_W    = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int Y_W    = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  state_t              r_state;
  state_t              w_next_state;
  logic                r_win_req;
  logic                r_pix_valid;
  logic [15:0]         r_pix_data;
  logic [1:0]          r_color_idx;
  logic                r_frame_done;
  logic                r_busy;
  logic [HOLD_W-1:0]   r_hold_cnt;

  logic                w_xfer;
  logic                w_last_pixel;
  logic                w_frame_end;
  logic                w_hold_exit;
  logic [1:0]          w_color_next;
  logic [X_W-1:0]      w_x;
  logic [Y_W-1:0]      w_y;
  logic                w_unused_xy;

  assign w_xfer       = r_pix_valid & pix_ready;
  assign w_frame_end  = w_xfer & w_last_pixel;
  assign w_hold_exit  = (r_state == HOLD) && (r_hold_cnt == '0);
  assign w_color_next = r_color_idx + 2'd1;

  ili9488_frame_counter #(
    .H_RES(H_RES),
    .V_RES(V_RES)
  ) u_frame_counter (
    .clk          (clk),
    .reset_done   (reset_done),
    .i_advance    (w_xfer),
    .o_x          (w_x),
    .o_y          (w_y),
    .o_last_pixel (w_last_pixel)
  );

  // Raster position matters only to pattern writers; a solid fill needs just the frame end.
  assign w_unused_xy = ^{w_x, w_y};

  always_ff @(posedge clk or posedge reset_done) begin
    if (reset_done) r_state <= IDLE;
    else            r_state <= w_next_state;
  end

  // NOTE: default assignment first so no path through the case leaves w_next_state unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:   if (init_done && enable) w_next_state = WINDOW;
      WINDOW: if (win_ack)             w_next_state = FILL;
      FILL:   if (w_frame_end)         w_next_state = HOLD;
      HOLD:   if (w_hold_exit)         w_next_state = enable ? WINDOW : IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset_done) begin
    if (reset_done) begin
      r_win_req    <= 1'b0;
      r_pix_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_color_idx  <= 2'd0;
      r_pix_data   <= COLOR_RED;
      r_hold_cnt   <= '0;
    end else begin
      r_win_req    <= (w_next_state == WINDOW);
      r_pix_valid  <= (w_next_state == FILL);
      r_busy       <= (w_next_state != IDLE);
      r_frame_done <= w_frame_end;
      if (w_hold_exit) begin
        r_color_idx <= w_color_next;
        r_pix_data  <= palette(w_color_next);
      end
      if (w_frame_end)
        r_hold_cnt <= HOLD_LOAD;
      else if ((r_state == HOLD) && (r_hold_cnt != '0))
        r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
    end
  end

  assign win_req    = r_win_req;
  assign pix_valid  = r_pix_valid;
  assign pix_data   = r_pix_data;
  assign color_idx  = r_color_idx;
  assign frame_done = r_frame_done;
  assign busy       = r_busy;

endmodule

// File: tb/tb_ili9488_fill_sequencer.sv
// Directed bench for the fill sequencer with a frame-level scoreboard checked on every falling edge.
module tb_ili9488_fill_sequencer;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int HC = 3;
  localparam int HV = H * V;

  logic        clk = 1'b0;
  logic        reset_done = 1'b1;
  logic        init_done = 1'b0;
  logic        enable = 1'b0;
  logic        win_ack = 1'b0;
  logic        pix_ready = 1'b0;
  logic        win_req, pix_valid, frame_done, busy;
  logic [15:0] pix_data;
  logic [1:0]  color_idx;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] pal [4] = '{16'hF800, 16'h07E0, 16'h001F, 16'h0000};

  // Scoreboard: frames completed, transfers in the current frame, hold timing, first pixel per frame.
  int          frames = 0;
  int          xfers = 0;
  int          last_xfers = 0;
  int          hold_elapsed = 0;
  bit          hold_pending = 1'b0;
  bit          m_xfer;
  logic [15:0] first_px [$];
  logic [1:0]  win_colors [$];
  logic        p_valid = 1'b0, p_ready = 1'b0, p_win_req = 1'b0, p_win_ack = 1'b0;
  logic        p_xfer = 1'b0, p_fd = 1'b0;
  logic [15:0] p_data = '0;

  ili9488_fill_sequencer #(
    .H_RES(H),
    .V_RES(V),
    .HOLD_CYCLES(HC)
  ) dut (
    .clk        (clk),
    .reset_done (reset_done),
    .init_done  (init_done),
    .enable     (enable),
    .win_req    (win_req),
    .win_ack    (win_ack),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .color_idx  (color_idx),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (reset_done) begin
      frames = 0; xfers = 0; last_xfers = 0; hold_elapsed = 0; hold_pending = 1'b0;
      first_px.delete();
      p_valid = 1'b0; p_ready = 1'b0; p_win_req = 1'b0; p_win_ack = 1'b0;
      p_xfer = 1'b0; p_fd = 1'b0; p_data = '0;
    end else begin
      m_xfer = pix_valid && pix_ready;
      check("palette_match", pix_data, pal[color_idx]);
      if (p_win_req && p_win_ack) check("ack_to_valid", {pix_valid, win_req}, 2'b10);
      if (p_valid && !p_ready)    check("stall_hold", {pix_valid, pix_data}, {1'b1, p_data});
      if (frame_done) begin
        check("fd_after_xfer", p_xfer, 1);
        check("fd_xfer_count", xfers, HV);
        check("fd_valid_low", pix_valid, 0);
        check("fd_single_pulse", p_fd, 0);
        last_xfers = xfers; xfers = 0; frames++;
        hold_pending = 1'b1; hold_elapsed = 0;
      end else if (hold_pending) begin
        hold_elapsed++;
        if (win_req || !busy) begin
          check("hold_length", hold_elapsed, HC);
          hold_pending = 1'b0;
        end
      end
      if (m_xfer) begin
        if (xfers == 0) first_px.push_back(pix_data);
        check("xfer_color", pix_data, pal[frames % 4]);
        xfers++;
      end
      if (win_req && !p_win_req) check("window_color_idx", color_idx, frames % 4);
      if (!busy) check("idle_quiet", {win_req, pix_valid}, 2'b00);
      p_valid = pix_valid; p_ready = pix_ready; p_data = pix_data;
      p_win_req = win_req; p_win_ack = win_ack; p_xfer = m_xfer; p_fd = frame_done;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_win_req();
    for (int i = 0; i < 50; i++) begin
      if (win_req) return;
      step();
    end
    check("win_req_timeout", win_req, 1);
  endtask

  // One frame: wait for the window request, ack after ack_delay cycles, stream until frame_done.
  task automatic run_frame(input int ack_delay, input bit bp, input bit spur, input int drop_at);
    wait_win_req();
    win_colors.push_back(color_idx);
    for (int i = 0; i < ack_delay; i++) begin
      check("win_req_held", win_req, 1);
      step();
    end
    win_ack = 1'b1;
    step();
    check("valid_after_ack", {pix_valid, win_req}, 2'b10);
    win_ack = 1'b0;
    for (int c = 0; c < 200; c++) begin
      pix_ready = bp ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      win_ack   = spur ? c[0] : 1'b0;
      if (c == drop_at) enable = 1'b0;
      step();
      if (frame_done) begin
        win_ack   = 1'b0;
        pix_ready = 1'b1;
        return;
      end
    end
    check("frame_done_timeout", frame_done, 1);
  endtask

  logic [15:0] exp_px  [5] = '{16'hF800, 16'h07E0, 16'h001F, 16'h0000, 16'hF800};
  logic [1:0]  exp_idx [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    step(3);
    reset_done = 1'b0;

    // Idle with init_done low: nothing may start.
    enable = 1'b1;
    step(100);
    check("idle_win_req", win_req, 0);
    check("idle_pix_valid", pix_valid, 0);
    check("idle_busy", busy, 0);
    check("idle_pix_data", pix_data, 16'hF800);
    check("idle_color_idx", color_idx, 0);
    check("idle_frame_done", frame_done, 0);

    // Start: win_req one cycle after init_done, ack after 5 cycles, 8 red pixels.
    init_done = 1'b1;
    pix_ready = 1'b1;
    step();
    check("start_win_req", win_req, 1);
    check("start_busy", busy, 1);
    run_frame(5, 1'b0, 1'b0, -1);
    step();
    check("frame0_xfers", last_xfers, 8);

    // Backpressure frame with pix_ready 1,0,0,1,...
    run_frame(1, 1'b1, 1'b0, -1);
    step();
    check("frame1_bp_xfers", last_xfers, 8);

    // Remaining frames of the colour wrap.
    for (int f = 2; f < 5; f++) run_frame(f - 1, 1'b0, 1'b0, -1);
    step();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("wrap_first_px_%0d", i), first_px[i], exp_px[i]);
      check($sformatf("wrap_color_idx_%0d", i), win_colors[i], exp_idx[i]);
    end

    // Asynchronous reset in the middle of a frame.
    wait_win_req();
    win_ack = 1'b1;
    step();
    win_ack = 1'b0;
    step(3);
    check("pre_reset_in_fill", pix_valid, 1);
    #1 reset_done = 1'b1;
    #1;
    check("rst_win_req", win_req, 0);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_busy", busy, 0);
    check("rst_color_idx", color_idx, 0);
    check("rst_pix_data", pix_data, 16'hF800);
    step();
    reset_done = 1'b0;

    // Enable gating: drop enable mid-fill of the second frame, sequencer parks after its hold.
    run_frame(2, 1'b0, 1'b0, -1);
    run_frame(1, 1'b0, 1'b0, 3);
    step(6);
    check("park_busy", busy, 0);
    check("park_color_idx", color_idx, 2);
    check("park_win_req", win_req, 0);
    check("park_frames", frames, 2);
    enable = 1'b1;
    wait_win_req();
    check("resume_pix_data", pix_data, 16'h001F);
    check("resume_color_idx", color_idx, 2);

    // Spurious win_ack during fill and hold, pix_ready toggling in hold, init_done dropped.
    init_done = 1'b0;
    run_frame(0, 1'b0, 1'b1, -1);
    win_ack = 1'b1; pix_ready = 1'b1;
    step();
    win_ack = 1'b1; pix_ready = 1'b0;
    step();
    win_ack = 1'b0; pix_ready = 1'b1;
    run_frame(1, 1'b0, 1'b0, -1);
    step();
    check("spur_frames", frames, 4);
    check("spur_last_xfers", last_xfers, 8);
    for (int i = 0; i < 4; i++)
      check($sformatf("post_reset_first_px_%0d", i), first_px[i], exp_px[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
